counter_step_monitor: RTL and testbench
=======================================

// Module: counter_step_monitor
// PURPOSE
// - Downstream checker for the 4-bit up/down counter: samples its count output and its up_down control every clk.
// - Verifies every cycle-to-cycle step is exactly +1 (up_down=0) or -1 (up_down=1), modulo 2^WIDTH.
// - Reports wrap-around events, direction changes, step errors and a latched fault state to system/debug logic.
// PARAMETERS
// - WIDTH       4  width of monitored count bus
// - WRAP_CNT_W  8  width of saturating wrap-event counter
// - ERR_LIMIT   3  consecutive step errors that force FAULT (range 1..15)
// PORTS
// - clk               in   1           system clock, all logic on rising edge
// - reset             in   1           synchronous, active-low reset (0 = reset)
// - up_down           in   1           counter direction: 0 = up, 1 = down (same net that drives the counter)
// - count_in          in   WIDTH       counter output value
// - clr               in   1           sync clear of wrap_count, err_sticky, FAULT (active-high)
// - locked            out  1           1 while in TRACK state
// - wrap_pulse        out  1           1-cycle pulse on detected wrap
// - dir_change_pulse  out  1           1-cycle pulse when registered up_down toggles
// - step_err          out  1           1-cycle pulse on illegal step
// - err_sticky        out  1           set on any step_err, held until clr or reset
// - wrap_count        out  WRAP_CNT_W  number of wraps, saturates at all-ones
// BEHAVIOUR
// - Registers prev_cnt, prev_dir each cycle; expected = prev_dir ? prev_cnt-1 : prev_cnt+1, truncated to WIDTH.
// - Reset (reset==0 at edge): state=ACQUIRE; all outputs 0; prev_cnt=0, prev_dir=0, err_run=0. Reset beats clr.
// - FSM:
//   ACQUIRE: capture count_in/up_down, no comparison; next cycle -> TRACK. locked=0.
//   TRACK:   compare count_in vs expected; locked=1. err_run counts consecutive errors, cleared by a good step.
//            err_run reaching ERR_LIMIT -> FAULT (same edge as the ERR_LIMIT-th step_err).
//   FAULT:   locked=0; comparisons continue, step_err still pulses, wrap detection disabled; exit only via clr -> ACQUIRE.
// - Latency: all pulses registered, assert the cycle after the offending count_in sample (1-cycle latency).
// - Wrap: up: prev_cnt==2^WIDTH-1 & count_in==0; down: prev_cnt==0 & count_in==2^WIDTH-1; only on legal step in TRACK.
// - wrap_count += 1 per wrap_pulse; saturates, never rolls over.
// - dir_change_pulse: up_down != prev_dir in TRACK or FAULT; independent of step legality.
// - Simultaneous clr & wrap/error: clr wins; counters/sticky cleared, pulse suppressed, state -> ACQUIRE.
// - Direction change: step checked against prev_dir (direction in force when the counter updated), not current up_down.
// - Any step other than expected (incl. zero step, jumps) is an error unless macro below applies.
// CONFIGURATION
// - COUNTER_MON_HOLD_EN defined: count_in==prev_cnt is legal (hold); no error, no wrap, err_run unchanged.
// - Not defined: hold is a step error like any other mismatch.
// TESTING
// - Reset 2 cycles, then count 0,1,2..15,0 with up_down=0 -> locked=1 from cycle 2, one wrap_pulse, wrap_count=1, no step_err.
// - Up to 5, set up_down=1, count 6,5,4 -> one dir_change_pulse, no step_err, locked stays 1.
// - Count down 1,0,15 (up_down=1) -> wrap_pulse on 0->15, wrap_count increments.
// - Inject 3->7 once, then legal steps -> one step_err, err_sticky=1, locked stays 1, err_run cleared.
// - Three consecutive bad samples (ERR_LIMIT=3) -> state FAULT, locked=0; clr=1 -> err_sticky=0, wrap_count=0, ACQUIRE then TRACK.
// - Hold 9,9: without COUNTER_MON_HOLD_EN -> step_err; with it -> no step_err; reset=0 mid-run -> all outputs 0 next cycle.

Source files
------------

// File: rtl/counter_step_monitor.sv
// rtl/counter_step_monitor.sv - step/wrap/direction checker for an up/down counter.
// Optional: COUNTER_MON_HOLD_EN makes a zero step (count_in == prev_cnt) legal.
module counter_step_monitor #(
  parameter int WIDTH      = 4,
  parameter int WRAP_CNT_W = 8,
  parameter int ERR_LIMIT  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  up_down,
  input  logic [WIDTH-1:0]      count_in,
  input  logic                  clr,
  output logic                  locked,
  output logic                  wrap_pulse,
  output logic                  dir_change_pulse,
  output logic                  step_err,
  output logic                  err_sticky,
  output logic [WRAP_CNT_W-1:0] wrap_count
);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    TRACK   = 2'd1,
    FAULT   = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0]      CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0]      CNT_MAX  = '1;
  localparam logic [WIDTH-1:0]      CNT_ZERO = '0;
  localparam logic [WRAP_CNT_W-1:0] WC_ONE   = WRAP_CNT_W'(1);
  localparam logic [WRAP_CNT_W-1:0] WC_MAX   = '1;
  localparam logic [3:0]            ERR_LIM  = 4'(ERR_LIMIT);

  state_t                  state, state_nxt;
  logic [WIDTH-1:0]        prev_cnt;
  logic                    prev_dir;
  logic [3:0]              err_run, err_run_nxt, err_run_inc;
  logic [WIDTH-1:0]        expected;
  logic                    hold, mismatch, bad, legal, wrap_hit;
  logic                    wrap_nxt, dir_nxt, err_nxt, sticky_nxt;
  logic [WRAP_CNT_W-1:0]   wrap_count_nxt;

  assign expected    = prev_dir ? (prev_cnt - CNT_ONE) : (prev_cnt + CNT_ONE);
  assign mismatch    = (count_in != expected);
`ifdef COUNTER_MON_HOLD_EN
  assign hold        = (count_in == prev_cnt);
`else
  assign hold        = 1'b0;
`endif
  assign bad         = mismatch && !hold;
  assign legal       = !mismatch;
  assign wrap_hit    = legal && (prev_dir ? (prev_cnt == CNT_ZERO && count_in == CNT_MAX)
                                          : (prev_cnt == CNT_MAX && count_in == CNT_ZERO));
  assign err_run_inc = (err_run == 4'hF) ? err_run : (err_run + 4'd1);
  assign locked      = (state == TRACK);

  always_comb begin
    state_nxt      = state;
    err_run_nxt    = err_run;
    wrap_nxt       = 1'b0;
    dir_nxt        = 1'b0;
    err_nxt        = 1'b0;
    sticky_nxt     = err_sticky;
    wrap_count_nxt = wrap_count;

    case (state)
      ACQUIRE: begin
        state_nxt   = TRACK;
        err_run_nxt = 4'd0;
      end
      TRACK: begin
        dir_nxt = (up_down != prev_dir);
        err_nxt = bad;
        if (bad) begin
          err_run_nxt = err_run_inc;
          sticky_nxt  = 1'b1;
          if (err_run_inc >= ERR_LIM) state_nxt = FAULT;
        end else if (!hold) begin
          err_run_nxt = 4'd0;
        end
        wrap_nxt = wrap_hit;
        if (wrap_hit && wrap_count != WC_MAX) wrap_count_nxt = wrap_count + WC_ONE;
      end
      FAULT: begin
        // Checking continues so the debug side still sees errors; wraps are ignored.
        dir_nxt = (up_down != prev_dir);
        err_nxt = bad;
        if (bad) begin
          err_run_nxt = err_run_inc;
          sticky_nxt  = 1'b1;
        end else if (!hold) begin
          err_run_nxt = 4'd0;
        end
      end
      default: state_nxt = ACQUIRE;
    endcase

    if (clr) begin
      state_nxt      = ACQUIRE;
      err_run_nxt    = 4'd0;
      wrap_nxt       = 1'b0;
      dir_nxt        = 1'b0;
      err_nxt        = 1'b0;
      sticky_nxt     = 1'b0;
      wrap_count_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= ACQUIRE;
      prev_cnt         <= '0;
      prev_dir         <= 1'b0;
      err_run          <= 4'd0;
      wrap_pulse       <= 1'b0;
      dir_change_pulse <= 1'b0;
      step_err         <= 1'b0;
      err_sticky       <= 1'b0;
      wrap_count       <= '0;
    end else begin
      state            <= state_nxt;
      prev_cnt         <= count_in;
      prev_dir         <= up_down;
      err_run          <= err_run_nxt;
      wrap_pulse       <= wrap_nxt;
      dir_change_pulse <= dir_nxt;
      step_err         <= err_nxt;
      err_sticky       <= sticky_nxt;
      wrap_count       <= wrap_count_nxt;
    end
  end

endmodule

// File: tb/tb_counter_step_monitor.sv
// tb/tb_counter_step_monitor.sv - directed vectors with a queue scoreboard for counter_step_monitor.
module tb_counter_step_monitor;

  typedef struct {
    logic       locked;
    logic       wrap;
    logic       dir;
    logic       err;
    logic       sticky;
    logic [7:0] wc;
    int         idx;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       up_down;
  logic [3:0] count_in;
  logic       clr;
  logic       locked, wrap_pulse, dir_change_pulse, step_err, err_sticky;
  logic [7:0] wrap_count;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vec_idx  = 0;

`ifdef COUNTER_MON_HOLD_EN
  localparam logic HOLD_ERR = 1'b0;
`else
  localparam logic HOLD_ERR = 1'b1;
`endif

  counter_step_monitor #(.WIDTH(4), .WRAP_CNT_W(8), .ERR_LIMIT(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .up_down          (up_down),
    .count_in         (count_in),
    .clr              (clr),
    .locked           (locked),
    .wrap_pulse       (wrap_pulse),
    .dir_change_pulse (dir_change_pulse),
    .step_err         (step_err),
    .err_sticky       (err_sticky),
    .wrap_count       (wrap_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec=%0d actual=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  // Drive one sample and queue the outputs expected right after the next rising edge.
  task automatic vec(input logic r, input logic ud, input logic [3:0] c, input logic cl,
                     input logic e_lock, input logic e_wrap, input logic e_dir,
                     input logic e_err, input logic e_sticky, input logic [7:0] e_wc);
    exp_t e;
    @(negedge clk);
    reset    = r;
    up_down  = ud;
    count_in = c;
    clr      = cl;
    e.locked = e_lock;
    e.wrap   = e_wrap;
    e.dir    = e_dir;
    e.err    = e_err;
    e.sticky = e_sticky;
    e.wc     = e_wc;
    e.idx    = vec_idx;
    vec_idx++;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("locked",           e.idx, {31'd0, locked},           {31'd0, e.locked});
        chk("wrap_pulse",       e.idx, {31'd0, wrap_pulse},       {31'd0, e.wrap});
        chk("dir_change_pulse", e.idx, {31'd0, dir_change_pulse}, {31'd0, e.dir});
        chk("step_err",         e.idx, {31'd0, step_err},         {31'd0, e.err});
        chk("err_sticky",       e.idx, {31'd0, err_sticky},       {31'd0, e.sticky});
        chk("wrap_count",       e.idx, {24'd0, wrap_count},       {24'd0, e.wc});
      end
    end
  end

  initial begin : stimulus
    reset = 1'b0; up_down = 1'b0; count_in = 4'd0; clr = 1'b0;
    // reset, then full up count with one wrap
    vec(0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 8'd0);
    vec(0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 8'd0);
    vec(1, 0, 4'd0, 0, 1, 0, 0, 0, 0, 8'd0);
    for (int i = 1; i < 16; i++) vec(1, 0, 4'(i), 0, 1, 0, 0, 0, 0, 8'd1 - 8'd1);
    vec(1, 0, 4'd0, 0, 1, 1, 0, 0, 0, 8'd1);
    // up to 5, reverse direction while counter still steps up once
    for (int i = 1; i < 6; i++) vec(1, 0, 4'(i), 0, 1, 0, 0, 0, 0, 8'd1);
    vec(1, 1, 4'd6, 0, 1, 0, 1, 0, 0, 8'd1);
    vec(1, 1, 4'd5, 0, 1, 0, 0, 0, 0, 8'd1);
    vec(1, 1, 4'd4, 0, 1, 0, 0, 0, 0, 8'd1);
    // down through zero
    for (int i = 3; i >= 0; i--) vec(1, 1, 4'(i), 0, 1, 0, 0, 0, 0, 8'd1);
    vec(1, 1, 4'd15, 0, 1, 1, 0, 0, 0, 8'd2);
    vec(1, 1, 4'd14, 0, 1, 0, 0, 0, 0, 8'd2);
    vec(1, 0, 4'd13, 0, 1, 0, 1, 0, 0, 8'd2);
    vec(1, 0, 4'd14, 0, 1, 0, 0, 0, 0, 8'd2);
    vec(1, 0, 4'd15, 0, 1, 0, 0, 0, 0, 8'd2);
    vec(1, 0, 4'd0,  0, 1, 1, 0, 0, 0, 8'd3);
    for (int i = 1; i < 4; i++) vec(1, 0, 4'(i), 0, 1, 0, 0, 0, 0, 8'd3);
    // single bad jump 3->7, then recovery
    vec(1, 0, 4'd7, 0, 1, 0, 0, 1, 1, 8'd3);
    vec(1, 0, 4'd8, 0, 1, 0, 0, 0, 1, 8'd3);
    vec(1, 0, 4'd9, 0, 1, 0, 0, 0, 1, 8'd3);
    // three consecutive errors: still locked after two, FAULT on the third
    vec(1, 0, 4'd2,  0, 1, 0, 0, 1, 1, 8'd3);
    vec(1, 0, 4'd12, 0, 1, 0, 0, 1, 1, 8'd3);
    vec(1, 0, 4'd5,  0, 0, 0, 0, 1, 1, 8'd3);
    vec(1, 0, 4'd6,  0, 0, 0, 0, 0, 1, 8'd3);
    vec(1, 0, 4'd7,  0, 0, 0, 0, 0, 1, 8'd3);
    vec(1, 1, 4'd8,  0, 0, 0, 1, 0, 1, 8'd3);
    for (int i = 7; i >= 0; i--) vec(1, 1, 4'(i), 0, 0, 0, 0, 0, 1, 8'd3);
    vec(1, 1, 4'd15, 0, 0, 0, 0, 0, 1, 8'd3);
    // clr on an illegal step: clr wins, back to ACQUIRE then TRACK
    vec(1, 1, 4'd3, 1, 0, 0, 0, 0, 0, 8'd0);
    vec(1, 1, 4'd2, 0, 1, 0, 0, 0, 0, 8'd0);
    vec(1, 1, 4'd1, 0, 1, 0, 0, 0, 0, 8'd0);
    vec(1, 1, 4'd0, 0, 1, 0, 0, 0, 0, 8'd0);
    // clr on a wrapping step: wrap suppressed
    vec(1, 1, 4'd15, 1, 0, 0, 0, 0, 0, 8'd0);
    vec(1, 1, 4'd14, 0, 1, 0, 0, 0, 0, 8'd0);
    vec(1, 1, 4'd13, 0, 1, 0, 0, 0, 0, 8'd0);
    // hold step
    vec(1, 1, 4'd13, 0, 1, 0, 0, HOLD_ERR, HOLD_ERR, 8'd0);
    vec(1, 1, 4'd12, 0, 1, 0, 0, 0, HOLD_ERR, 8'd0);
    // reset mid-run
    vec(0, 1, 4'd11, 0, 0, 0, 0, 0, 0, 8'd0);
    vec(1, 1, 4'd10, 0, 1, 0, 0, 0, 0, 8'd0);
    vec(1, 1, 4'd9,  0, 1, 0, 0, 0, 0, 8'd0);

    repeat (4) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
